c64_keyboard_matrix: RTL
========================

// Module: c64_keyboard_matrix
// PURPOSE
//  Upstream of CIA1 port inputs. Decodes PS/2 set-2 scancode bytes into a 64-key C64 matrix.
//  Resolves the matrix against CIA port outputs into pa_in/pb_in, sampled on phi2_p.
//  Maps one extra key to RESTORE (NMI line), outside the matrix.
// PARAMETERS
//  RESTORE_CODE  8'h7D  E0-prefixed scancode mapped to RESTORE (PgUp)
//  RESET_CODE    8'hAA  keyboard BAT byte; releases all keys
// PORTS
//  clk         in   1  system clock
//  res_n       in   1  synchronous active-low reset
//  phi2_p      in   1  Phi2 positive-edge enable, same as CIA
//  kbd_strobe  in   1  one-cycle pulse: kbd_data valid
//  kbd_data    in   8  scancode byte
//  pa_out      in   8  CIA1 port A drive (low = row selected)
//  pb_out      in   8  CIA1 port B drive (low = column driven)
//  ext_pa_n    in   8  joystick 2 / other active-low sources, ANDed into pa_in
//  ext_pb_n    in   8  joystick 1 / other active-low sources, ANDed into pb_in
//  pa_in       out  8  to CIA1 pa_in
//  pb_in       out  8  to CIA1 pb_in
//  restore_n   out  1  RESTORE key, active low
//  key_any     out  1  high while any matrix key is held
// BEHAVIOUR
//  Reset: matrix = 0, FSM = IDLE, pa_in = pb_in = 8'hFF, restore_n = 1, key_any = 0.
//  FSM advances only on kbd_strobe, one byte per cycle; no backpressure.
//   IDLE: F0->BRK; E0->EXT; RESET_CODE->clear matrix & restore; else make(code,ext=0).
//   BRK: break(code,ext=0) ->IDLE.  EXT: F0->EXT_BRK; else make(code,ext=1) ->IDLE.
//   EXT_BRK: break(code,ext=1) ->IDLE.
//  E0 in BRK/EXT_BRK, or E0/F0 in EXT_BRK: discarded, state unchanged.
//  Lookup gives {hit, row[2:0], col[2:0]}. make sets key[row*8+col]; break clears it.
//  Misses are ignored. RESTORE_CODE with ext=1 drives restore_n (0 on make, 1 on break).
//  Make of an already-set key, or break of a cleared key: no change (typematic safe).
//  Resolve, combinational:
//   pb_raw[c] = ~|(key[r*8+c] & ~pa_out[r]) over r.
//   pa_raw[r] = ~|(key[r*8+c] & ~pb_out[c]) over c.
//   One pass only; no multi-key ghost propagation.
//  On phi2_p: pa_in <= pa_raw & ext_pa_n; pb_in <= pb_raw & ext_pb_n.
//   This is one Phi2 latency, which the CIA read path tolerates.
//  Matrix update and phi2_p in the same cycle: the resolve uses the pre-update matrix.
//  key_any = |key, registered on clk.
//  Reset mid-sequence (after F0/E0): FSM to IDLE, pending prefix lost.
// STRUCTURE
//  Package c64_kbd_pkg:
//   FSM state enum (IDLE, BRK, EXT, EXT_BRK).
//   Constants 8'hF0 / 8'hE0.
//   Function map_scancode(code, ext) returning {hit, row, col}.
//  Sub-module kbd_matrix_resolve: 64-bit key vector plus pa_out/pb_out in, pa_raw/pb_raw out.
// TESTING
//  Make 8'h1C (A), pa_out=8'hFD, pb_out=8'hFF -> pb_in=8'hFB after next phi2_p; pa_in=8'hFF.
//  Same key, pa_out=8'hFF, pb_out=8'hFB -> pa_in=8'hFD.
//  Then F0 1C -> pb_in=8'hFF.
//  Space 8'h29 + Return 8'h5A, pa_out=8'h00:
//   pb_in=8'hED, key_any=1.
//   Break Space -> pb_in=8'hFD.
//  E0 7D -> restore_n=0; E0 F0 7D -> restore_n=1; matrix untouched.
//  Hold LShift 8'h12 and A, then strobe 8'hAA:
//   matrix clears, key_any=0, pa_out=8'h00 -> pb_in=8'hFF.
//  Strobe F0, pulse res_n low, release, then 8'h1C -> A is pressed, not released.
//  A held, ext_pb_n=8'hEF, pa_out=8'hFD:
//   pb_in=8'hEB.
//   Strobe coincident with phi2_p -> old value this edge, new value next edge.

Source files
------------

// File: rtl/c64_kbd_pkg.sv
// Shared types, prefix constants and the PS/2 set-2 to C64 matrix map.
package c64_kbd_pkg;

    localparam int unsigned KEY_W  = 64;
    localparam int unsigned LINE_W = 8;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } kbd_state_e;

    typedef struct packed {
        logic       hit;
        logic [2:0] row;
        logic [2:0] col;
    } key_map_t;

    // Scancode to matrix position; rc is written in octal as row,col (PA bit, PB bit).
    function automatic key_map_t map_scancode(input logic [7:0] code, input logic ext);
        logic       hit;
        logic [5:0] rc;
        hit = 1'b1;
        rc  = '0;
        if (!ext) begin
            case (code)
                8'h66: rc = 6'o00;  8'h5A: rc = 6'o01;  8'h83: rc = 6'o03;  8'h05: rc = 6'o04;
                8'h04: rc = 6'o05;  8'h03: rc = 6'o06;
                8'h26: rc = 6'o10;  8'h1D: rc = 6'o11;  8'h1C: rc = 6'o12;  8'h25: rc = 6'o13;
                8'h1A: rc = 6'o14;  8'h1B: rc = 6'o15;  8'h24: rc = 6'o16;  8'h12: rc = 6'o17;
                8'h2E: rc = 6'o20;  8'h2D: rc = 6'o21;  8'h23: rc = 6'o22;  8'h36: rc = 6'o23;
                8'h21: rc = 6'o24;  8'h2B: rc = 6'o25;  8'h2C: rc = 6'o26;  8'h22: rc = 6'o27;
                8'h3D: rc = 6'o30;  8'h35: rc = 6'o31;  8'h34: rc = 6'o32;  8'h3E: rc = 6'o33;
                8'h32: rc = 6'o34;  8'h33: rc = 6'o35;  8'h3C: rc = 6'o36;  8'h2A: rc = 6'o37;
                8'h46: rc = 6'o40;  8'h43: rc = 6'o41;  8'h3B: rc = 6'o42;  8'h45: rc = 6'o43;
                8'h3A: rc = 6'o44;  8'h42: rc = 6'o45;  8'h44: rc = 6'o46;  8'h31: rc = 6'o47;
                8'h5B: rc = 6'o50;  8'h4D: rc = 6'o51;  8'h4B: rc = 6'o52;  8'h4E: rc = 6'o53;
                8'h49: rc = 6'o54;  8'h4C: rc = 6'o55;  8'h54: rc = 6'o56;  8'h41: rc = 6'o57;
                8'h5D: rc = 6'o60;  8'h52: rc = 6'o61;  8'h0D: rc = 6'o62;  8'h59: rc = 6'o64;
                8'h55: rc = 6'o65;  8'h4A: rc = 6'o67;
                8'h16: rc = 6'o70;  8'h0E: rc = 6'o71;  8'h14: rc = 6'o72;  8'h1E: rc = 6'o73;
                8'h29: rc = 6'o74;  8'h11: rc = 6'o75;  8'h15: rc = 6'o76;  8'h76: rc = 6'o77;
                default: hit = 1'b0;
            endcase
        end else begin
            case (code)
                8'h71: rc = 6'o00;  8'h5A: rc = 6'o01;  8'h74: rc = 6'o02;  8'h72: rc = 6'o07;
                8'h6C: rc = 6'o63;  8'h14: rc = 6'o72;  8'h1F: rc = 6'o75;
                default: hit = 1'b0;
            endcase
        end
        return '{hit: hit, row: rc[5:3], col: rc[2:0]};
    endfunction

endpackage

// File: rtl/kbd_matrix_resolve.sv
// Single-pass resolve of the key matrix against the CIA port drives.
module kbd_matrix_resolve
    import c64_kbd_pkg::*;
(
    input  logic [KEY_W-1:0]  key,
    input  logic [LINE_W-1:0] pa_out,
    input  logic [LINE_W-1:0] pb_out,
    output logic [LINE_W-1:0] pa_raw,
    output logic [LINE_W-1:0] pb_raw
);

    // A held key pulls its column low when its row is driven, and vice versa.
    always_comb begin
        pa_raw = '1;
        pb_raw = '1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (key[{3'(r), 3'(c)}] && !pa_out[r]) pb_raw[c] = 1'b0;
                if (key[{3'(r), 3'(c)}] && !pb_out[c]) pa_raw[r] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/c64_keyboard_matrix.sv
// PS/2 set-2 scancode decoder feeding a C64 keyboard matrix and RESTORE line.
module c64_keyboard_matrix
    import c64_kbd_pkg::*;
#(
    parameter logic [7:0] RESTORE_CODE = 8'h7D,
    parameter logic [7:0] RESET_CODE   = 8'hAA
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              phi2_p,
    input  logic              kbd_strobe,
    input  logic [7:0]        kbd_data,
    input  logic [LINE_W-1:0] pa_out,
    input  logic [LINE_W-1:0] pb_out,
    input  logic [LINE_W-1:0] ext_pa_n,
    input  logic [LINE_W-1:0] ext_pb_n,
    output logic [LINE_W-1:0] pa_in,
    output logic [LINE_W-1:0] pb_in,
    output logic              restore_n,
    output logic              key_any
);

    kbd_state_e        state_q, state_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [LINE_W-1:0] pa_in_q, pa_in_d, pb_in_q, pb_in_d;
    logic [LINE_W-1:0] pa_raw, pb_raw;
    logic              restore_n_q, restore_n_d;
    logic              key_any_q, key_any_d;
    logic              do_make, do_break, do_clear, lk_ext;
    key_map_t          lk;

    // Resolve always sees the registered (pre-update) matrix.
    kbd_matrix_resolve u_resolve (
        .key    (key_q),
        .pa_out (pa_out),
        .pb_out (pb_out),
        .pa_raw (pa_raw),
        .pb_raw (pb_raw)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!res_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Prefix tracking; stray prefixes inside a break sequence are swallowed.
    always_comb begin
        state_d = state_q;
        if (kbd_strobe) begin
            case (state_q)
                IDLE: begin
                    if (kbd_data == SC_BREAK)    state_d = BRK;
                    else if (kbd_data == SC_EXT) state_d = EXT;
                end
                BRK:     if (kbd_data != SC_EXT) state_d = IDLE;
                EXT:     state_d = (kbd_data == SC_BREAK) ? EXT_BRK : IDLE;
                EXT_BRK: if (kbd_data != SC_EXT && kbd_data != SC_BREAK) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Matrix / RESTORE updates and the phi2-sampled port values.
    always_comb begin
        do_make     = 1'b0;
        do_break    = 1'b0;
        do_clear    = 1'b0;
        lk_ext      = 1'b0;
        key_d       = key_q;
        restore_n_d = restore_n_q;
        if (kbd_strobe) begin
            case (state_q)
                IDLE: begin
                    if (kbd_data != SC_BREAK && kbd_data != SC_EXT) begin
                        if (kbd_data == RESET_CODE) do_clear = 1'b1;
                        else                        do_make  = 1'b1;
                    end
                end
                BRK: do_break = (kbd_data != SC_EXT);
                EXT: begin
                    lk_ext  = 1'b1;
                    do_make = (kbd_data != SC_BREAK);
                end
                EXT_BRK: begin
                    lk_ext   = 1'b1;
                    do_break = (kbd_data != SC_EXT && kbd_data != SC_BREAK);
                end
                default: ;
            endcase
        end
        lk = map_scancode(kbd_data, lk_ext);
        if (do_clear) begin
            key_d       = '0;
            restore_n_d = 1'b1;
        end
        if ((do_make || do_break) && lk_ext && kbd_data == RESTORE_CODE) restore_n_d = do_break;
        if (lk.hit && do_make)  key_d[{lk.row, lk.col}] = 1'b1;
        if (lk.hit && do_break) key_d[{lk.row, lk.col}] = 1'b0;
        pa_in_d   = phi2_p ? (pa_raw & ext_pa_n) : pa_in_q;
        pb_in_d   = phi2_p ? (pb_raw & ext_pb_n) : pb_in_q;
        key_any_d = |key_q;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            key_q       <= '0;
            pa_in_q     <= '1;
            pb_in_q     <= '1;
            restore_n_q <= 1'b1;
            key_any_q   <= 1'b0;
        end else begin
            key_q       <= key_d;
            pa_in_q     <= pa_in_d;
            pb_in_q     <= pb_in_d;
            restore_n_q <= restore_n_d;
            key_any_q   <= key_any_d;
        end
    end

    assign pa_in     = pa_in_q;
    assign pb_in     = pb_in_q;
    assign restore_n = restore_n_q;
    assign key_any   = key_any_q;

endmodule
